// File: rtl/lsu.sv
// Load/store unit: takes one memory instruction from exe_mem, runs a single
// word-aligned bus transaction (with timeout), and hands a registered result
// or exception to mem_wb as a one-cycle pulse.
module lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic [3:0]            mem_op_i,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [31:0]           mem_data_i,
    input  logic [4:0]            reg_waddr_i,
    input  logic                  reg_we_i,
    input  logic [31:0]           reg_wdata_i,
    output logic                  stall_o,
    output logic                  bus_req_o,
    output logic                  bus_we_o,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic [3:0]            bus_be_o,
    output logic [31:0]           bus_wdata_o,
    input  logic                  bus_ack_i,
    input  logic                  bus_err_i,
    input  logic [31:0]           bus_rdata_i,
    output logic                  wb_valid_o,
    output logic [4:0]            reg_waddr_o,
    output logic                  reg_we_o,
    output logic [31:0]           reg_wdata_o,
    output logic                  exc_valid_o,
    output logic [3:0]            exc_cause_o,
    output logic [ADDR_WIDTH-1:0] exc_tval_o
);

    // Memory operation encodings shared with the decode stage.
    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h1;
    localparam logic [3:0] OP_LH   = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_LBU  = 4'h4;
    localparam logic [3:0] OP_LHU  = 4'h5;
    localparam logic [3:0] OP_SB   = 4'h6;
    localparam logic [3:0] OP_SH   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [7:0]  cycle_cnt;
    logic [3:0]  op_q;
    logic [1:0]  off_q;
    logic [4:0]  waddr_q;
    logic        we_q;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic        accept;
    logic        timeout_hit;
    logic        done;
    logic        fault;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Classify the incoming op; unknown encodings behave like NONE.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU: is_load = 1'b1;
            OP_LH, OP_LHU: begin
                is_load    = 1'b1;
                misaligned = mem_addr_i[0];
            end
            OP_LW: begin
                is_load    = 1'b1;
                misaligned = |mem_addr_i[1:0];
            end
            OP_SB: is_store = 1'b1;
            OP_SH: begin
                is_store   = 1'b1;
                misaligned = mem_addr_i[0];
            end
            OP_SW: begin
                is_store   = 1'b1;
                misaligned = |mem_addr_i[1:0];
            end
            default: ;
        endcase
    end

    // Byte enables and lane-replicated store data; loads always read the whole word.
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = mem_data_i;
        case (mem_op_i)
            OP_SB: begin
                be_next    = 4'b0001 << mem_addr_i[1:0];
                wdata_next = {4{mem_data_i[7:0]}};
            end
            OP_SH: begin
                be_next    = 4'b0011 << mem_addr_i[1:0];
                wdata_next = {2{mem_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half out of the read word and extend it.
    always_comb begin
        shifted = bus_rdata_i >> {off_q, 3'b000};
        case (op_q)
            OP_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:  load_data = {24'b0, shifted[7:0]};
            OP_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU:  load_data = {16'b0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign accept      = (state == IDLE) && valid_i && (is_load || is_store) && !misaligned;
    assign timeout_hit = (state == BUSY) && (cycle_cnt == 8'(TIMEOUT - 1));
    assign done        = (state == BUSY) && (bus_ack_i || bus_err_i || timeout_hit);
    assign fault       = bus_err_i || (timeout_hit && !bus_ack_i);
    assign stall_o     = rst_n_i && (accept || ((state == BUSY) && !done));

    // Main sequencer: accepts instructions, holds the bus request, produces result pulses.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cycle_cnt   <= 8'd0;
            op_q        <= OP_NONE;
            off_q       <= 2'd0;
            waddr_q     <= 5'd0;
            we_q        <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_be_o    <= 4'd0;
            bus_wdata_o <= 32'd0;
            wb_valid_o  <= 1'b0;
            reg_waddr_o <= 5'd0;
            reg_we_o    <= 1'b0;
            reg_wdata_o <= 32'd0;
            exc_valid_o <= 1'b0;
            exc_cause_o <= 4'd0;
            exc_tval_o  <= '0;
        end else begin
            wb_valid_o  <= 1'b0;
            reg_we_o    <= 1'b0;
            exc_valid_o <= 1'b0;
            if (state == IDLE) begin
                if (valid_i) begin
                    if (!(is_load || is_store)) begin
                        wb_valid_o  <= 1'b1;
                        reg_waddr_o <= reg_waddr_i;
                        reg_we_o    <= reg_we_i;
                        reg_wdata_o <= reg_wdata_i;
                    end else if (misaligned) begin
                        wb_valid_o  <= 1'b1;
                        reg_waddr_o <= reg_waddr_i;
                        exc_valid_o <= 1'b1;
                        exc_cause_o <= is_store ? 4'd6 : 4'd4;
                        exc_tval_o  <= mem_addr_i;
                    end else begin
                        state       <= BUSY;
                        cycle_cnt   <= 8'd0;
                        op_q        <= mem_op_i;
                        off_q       <= mem_addr_i[1:0];
                        waddr_q     <= reg_waddr_i;
                        we_q        <= reg_we_i;
                        bus_req_o   <= 1'b1;
                        bus_we_o    <= is_store;
                        bus_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_o    <= be_next;
                        bus_wdata_o <= wdata_next;
                    end
                end
            end else begin
                if (done) begin
                    state       <= IDLE;
                    bus_req_o   <= 1'b0;
                    bus_we_o    <= 1'b0;
                    wb_valid_o  <= 1'b1;
                    reg_waddr_o <= waddr_q;
                    if (fault) begin
                        exc_valid_o <= 1'b1;
                        exc_cause_o <= bus_we_o ? 4'd7 : 4'd5;
                        exc_tval_o  <= {bus_addr_o[ADDR_WIDTH-1:2], off_q};
                    end else if (!bus_we_o) begin
                        reg_we_o    <= we_q;
                        reg_wdata_o <= load_data;
                    end
                end else begin
                    cycle_cnt <= cycle_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Testbench for lsu: directed table of transactions, hand-written corner
// sequences (reset, back-to-back, reset mid-transaction) and randomized
// transactions checked against a transaction-level reference model.
module tb_lsu;

    localparam int TIMEOUT = 16;

    localparam logic [3:0] OP_NONE = 4'h0;
    localparam logic [3:0] OP_LB   = 4'h1;
    localparam logic [3:0] OP_LH   = 4'h2;
    localparam logic [3:0] OP_LW   = 4'h3;
    localparam logic [3:0] OP_LBU  = 4'h4;
    localparam logic [3:0] OP_LHU  = 4'h5;
    localparam logic [3:0] OP_SB   = 4'h6;
    localparam logic [3:0] OP_SH   = 4'h7;
    localparam logic [3:0] OP_SW   = 4'h8;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        int          resp_cycle;
        logic        resp_ack;
        logic        resp_err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        int          req_cycles;
        int          stall_cycles;
        logic        bwe;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] reg_wdata;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
    } exp_t;

    typedef struct {
        int          req_cycles;
        int          stall_cycles;
        logic        bwe;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] baddr;
        logic        unstable;
        logic        hung;
        logic        wb_valid;
        logic        reg_we;
        logic [4:0]  reg_waddr;
        logic [31:0] reg_wdata;
        logic        exc;
        logic [3:0]  cause;
        logic [31:0] tval;
        logic        req_after;
        logic        wb_after;
        logic        we_after;
        logic        exc_after;
    } obs_t;

    typedef struct {
        string name;
        vec_t  v;
        exp_t  e;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [4:0]  reg_waddr_i;
    logic        reg_we_i;
    logic [31:0] reg_wdata_i;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic        bus_err_i;
    logic [31:0] bus_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  reg_waddr_o;
    logic        reg_we_o;
    logic [31:0] reg_wdata_o;
    logic        exc_valid_o;
    logic [3:0]  exc_cause_o;
    logic [31:0] exc_tval_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    lsu #(.ADDR_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .valid_i     (valid_i),
        .mem_op_i    (mem_op_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .reg_waddr_i (reg_waddr_i),
        .reg_we_i    (reg_we_i),
        .reg_wdata_i (reg_wdata_i),
        .stall_o     (stall_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_be_o    (bus_be_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_ack_i   (bus_ack_i),
        .bus_err_i   (bus_err_i),
        .bus_rdata_i (bus_rdata_i),
        .wb_valid_o  (wb_valid_o),
        .reg_waddr_o (reg_waddr_o),
        .reg_we_o    (reg_we_o),
        .reg_wdata_o (reg_wdata_o),
        .exc_valid_o (exc_valid_o),
        .exc_cause_o (exc_cause_o),
        .exc_tval_o  (exc_tval_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] waddr, input logic we, input logic [31:0] wdata,
                                 input int rc, input logic ack, input logic err, input logic [31:0] rdata);
        vec_t v;
        v.op = op; v.addr = addr; v.data = data; v.waddr = waddr; v.we = we; v.wdata = wdata;
        v.resp_cycle = rc; v.resp_ack = ack; v.resp_err = err; v.rdata = rdata;
        return v;
    endfunction

    function automatic exp_t mke(input int req, input int stall, input logic bwe, input logic [3:0] be,
                                 input logic [31:0] bwdata, input logic [31:0] baddr, input logic rwe,
                                 input logic [4:0] rwaddr, input logic [31:0] rwdata, input logic exc,
                                 input logic [3:0] cause, input logic [31:0] tval);
        exp_t e;
        e.req_cycles = req; e.stall_cycles = stall; e.bwe = bwe; e.be = be; e.bwdata = bwdata;
        e.baddr = baddr; e.reg_we = rwe; e.reg_waddr = rwaddr; e.reg_wdata = rwdata;
        e.exc = exc; e.cause = cause; e.tval = tval;
        return e;
    endfunction

    function automatic rec_t mkr(input string name, input vec_t v, input exp_t e);
        rec_t r;
        r.name = name; r.v = v; r.e = e;
        return r;
    endfunction

    // Transaction-level reference: what the instruction should produce, given the
    // previously reported exception cause/tval (which must hold when nothing faults).
    function automatic exp_t model(input vec_t v, input logic [3:0] prev_cause, input logic [31:0] prev_tval);
        exp_t        e;
        bit          ld, st, sgn, fault;
        int          size;
        int          off;
        logic [63:0] field;
        e = mke(0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b0, prev_cause, prev_tval);
        ld = 0; st = 0; sgn = 0; size = 4;
        case (v.op)
            OP_LB:  begin ld = 1; size = 1; sgn = 1; end
            OP_LBU: begin ld = 1; size = 1; end
            OP_LH:  begin ld = 1; size = 2; sgn = 1; end
            OP_LHU: begin ld = 1; size = 2; end
            OP_LW:  begin ld = 1; size = 4; end
            OP_SB:  begin st = 1; size = 1; end
            OP_SH:  begin st = 1; size = 2; end
            OP_SW:  begin st = 1; size = 4; end
            default: ;
        endcase
        if (!ld && !st) begin
            e.reg_we = v.we; e.reg_waddr = v.waddr; e.reg_wdata = v.wdata;
            return e;
        end
        if ((v.addr % size) != 0) begin
            e.exc = 1'b1; e.cause = st ? 4'd6 : 4'd4; e.tval = v.addr;
            return e;
        end
        off = int'(v.addr % 4);
        e.req_cycles   = (v.resp_cycle == 0 || v.resp_cycle > TIMEOUT) ? TIMEOUT : v.resp_cycle;
        e.stall_cycles = e.req_cycles;
        fault = v.resp_err || (v.resp_cycle == 0) || (v.resp_cycle > TIMEOUT);
        e.bwe   = st;
        e.baddr = v.addr - off;
        if (st) begin
            e.be = 4'(((1 << size) - 1) << off);
            if (size == 1)      e.bwdata = {24'b0, v.data[7:0]} * 32'h01010101;
            else if (size == 2) e.bwdata = {16'b0, v.data[15:0]} * 32'h00010001;
            else                e.bwdata = v.data;
        end else begin
            e.be = 4'hF;
        end
        if (fault) begin
            e.exc = 1'b1; e.cause = st ? 4'd7 : 4'd5; e.tval = v.addr;
        end else if (ld) begin
            field = ({32'b0, v.rdata} >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
            if (sgn && field >= (64'd1 << (8 * size - 1))) field = field - (64'd1 << (8 * size));
            e.reg_we = v.we; e.reg_waddr = v.waddr; e.reg_wdata = field[31:0];
        end
        return e;
    endfunction

    // Present one instruction, play the bus side, and record what the DUT did.
    task automatic applyStimulus(input vec_t v, output obs_t o);
        int busy;
        bit done;
        o = '{default: 0};
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = v.op; mem_addr_i = v.addr; mem_data_i = v.data;
        reg_waddr_i = v.waddr; reg_we_i = v.we; reg_wdata_i = v.wdata;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = v.rdata;
        #1;
        if (stall_o) o.stall_cycles++;
        done = !stall_o;
        busy = 0;
        while (!done) begin
            @(negedge clk);
            if (!bus_req_o) begin
                done = 1;
            end else begin
                busy++;
                if (busy == 1) begin
                    o.bwe = bus_we_o; o.be = bus_be_o; o.bwdata = bus_wdata_o; o.baddr = bus_addr_o;
                end else if ({bus_we_o, bus_be_o, bus_wdata_o, bus_addr_o} !== {o.bwe, o.be, o.bwdata, o.baddr}) begin
                    o.unstable = 1'b1;
                end
                bus_ack_i = (busy == v.resp_cycle) && v.resp_ack;
                bus_err_i = (busy == v.resp_cycle) && v.resp_err;
                #1;
                if (stall_o) o.stall_cycles++;
                else done = 1;
                if (busy >= 200) begin
                    o.hung = 1'b1;
                    done = 1;
                end
            end
        end
        o.req_cycles = busy;
        @(negedge clk);
        valid_i = 1'b0; bus_ack_i = 1'b0; bus_err_i = 1'b0; mem_op_i = OP_NONE;
        #1;
        o.wb_valid = wb_valid_o; o.reg_we = reg_we_o; o.reg_waddr = reg_waddr_o; o.reg_wdata = reg_wdata_o;
        o.exc = exc_valid_o; o.cause = exc_cause_o; o.tval = exc_tval_o; o.req_after = bus_req_o;
        @(negedge clk);
        #1;
        o.wb_after = wb_valid_o; o.we_after = reg_we_o; o.exc_after = exc_valid_o;
    endtask

    task automatic checkTxn(input string name, input exp_t e, input obs_t o);
        checkOutput({name, ".hung"}, o.hung, 1'b0);
        checkOutput({name, ".wb_valid"}, o.wb_valid, 1'b1);
        checkOutput({name, ".reg_we"}, o.reg_we, e.reg_we);
        if (e.reg_we) begin
            checkOutput({name, ".reg_waddr"}, o.reg_waddr, e.reg_waddr);
            checkOutput({name, ".reg_wdata"}, o.reg_wdata, e.reg_wdata);
        end
        checkOutput({name, ".exc_valid"}, o.exc, e.exc);
        checkOutput({name, ".exc_cause"}, o.cause, e.cause);
        checkOutput({name, ".exc_tval"}, o.tval, e.tval);
        checkOutput({name, ".req_cycles"}, o.req_cycles, e.req_cycles);
        checkOutput({name, ".stall_cycles"}, o.stall_cycles, e.stall_cycles);
        if (e.req_cycles > 0) begin
            checkOutput({name, ".bus_we"}, o.bwe, e.bwe);
            checkOutput({name, ".bus_be"}, o.be, e.be);
            checkOutput({name, ".bus_addr"}, o.baddr, e.baddr);
            checkOutput({name, ".bus_stable"}, o.unstable, 1'b0);
            if (e.bwe) checkOutput({name, ".bus_wdata"}, o.bwdata, e.bwdata);
        end
        checkOutput({name, ".req_after"}, o.req_after, 1'b0);
        checkOutput({name, ".wb_pulse_end"}, o.wb_after, 1'b0);
        checkOutput({name, ".we_pulse_end"}, o.we_after, 1'b0);
        checkOutput({name, ".exc_pulse_end"}, o.exc_after, 1'b0);
    endtask

    initial begin
        rec_t        tbl[$];
        obs_t        o;
        exp_t        e;
        vec_t        v;
        logic [3:0]  ops[9];
        logic [3:0]  last_cause;
        logic [31:0] last_tval;
        int          n;

        ops = '{OP_NONE, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

        tbl.push_back(mkr("lb_sext_3wait", mkv(OP_LB, 32'h103, 32'h0, 5'd5, 1'b1, 32'h0, 3, 1'b1, 1'b0, 32'h80FFFF00),
                          mke(3, 3, 1'b0, 4'hF, 32'h0, 32'h100, 1'b1, 5'd5, 32'hFFFFFF80, 1'b0, 4'd0, 32'h0)));
        tbl.push_back(mkr("sh_off2_imm", mkv(OP_SH, 32'h202, 32'h1234ABCD, 5'd7, 1'b1, 32'h0, 1, 1'b1, 1'b0, 32'h0),
                          mke(1, 1, 1'b1, 4'hC, 32'hABCDABCD, 32'h200, 1'b0, 5'd0, 32'h0, 1'b0, 4'd0, 32'h0)));
        tbl.push_back(mkr("lw_misaligned", mkv(OP_LW, 32'h301, 32'h0, 5'd3, 1'b1, 32'h0, 1, 1'b1, 1'b0, 32'h0),
                          mke(0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 4'd4, 32'h301)));
        tbl.push_back(mkr("sw_timeout", mkv(OP_SW, 32'h400, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0),
                          mke(16, 16, 1'b1, 4'hF, 32'hDEADBEEF, 32'h400, 1'b0, 5'd0, 32'h0, 1'b1, 4'd7, 32'h400)));
        tbl.push_back(mkr("lw_ack_and_err", mkv(OP_LW, 32'h500, 32'h0, 5'd4, 1'b1, 32'h0, 2, 1'b1, 1'b1, 32'h11111111),
                          mke(2, 2, 1'b0, 4'hF, 32'h0, 32'h500, 1'b0, 5'd0, 32'h0, 1'b1, 4'd5, 32'h500)));
        tbl.push_back(mkr("none_passthru", mkv(OP_NONE, 32'h0, 32'h0, 5'd9, 1'b1, 32'hCAFEF00D, 0, 1'b0, 1'b0, 32'h0),
                          mke(0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 4'd5, 32'h500)));
        tbl.push_back(mkr("lhu_off2", mkv(OP_LHU, 32'h602, 32'h0, 5'd3, 1'b1, 32'h0, 1, 1'b1, 1'b0, 32'h80011234),
                          mke(1, 1, 1'b0, 4'hF, 32'h0, 32'h600, 1'b1, 5'd3, 32'h00008001, 1'b0, 4'd5, 32'h500)));
        tbl.push_back(mkr("lh_off2", mkv(OP_LH, 32'h702, 32'h0, 5'd3, 1'b1, 32'h0, 2, 1'b1, 1'b0, 32'h80011234),
                          mke(2, 2, 1'b0, 4'hF, 32'h0, 32'h700, 1'b1, 5'd3, 32'hFFFF8001, 1'b0, 4'd5, 32'h500)));
        tbl.push_back(mkr("sb_off1", mkv(OP_SB, 32'h801, 32'h1122335A, 5'd0, 1'b0, 32'h0, 1, 1'b1, 1'b0, 32'h0),
                          mke(1, 1, 1'b1, 4'b0010, 32'h5A5A5A5A, 32'h800, 1'b0, 5'd0, 32'h0, 1'b0, 4'd5, 32'h500)));
        tbl.push_back(mkr("lbu_off2", mkv(OP_LBU, 32'h902, 32'h0, 5'd31, 1'b1, 32'h0, 4, 1'b1, 1'b0, 32'h00AB0000),
                          mke(4, 4, 1'b0, 4'hF, 32'h0, 32'h900, 1'b1, 5'd31, 32'h000000AB, 1'b0, 4'd5, 32'h500)));
        tbl.push_back(mkr("sh_misaligned", mkv(OP_SH, 32'hA01, 32'h1, 5'd0, 1'b0, 32'h0, 1, 1'b1, 1'b0, 32'h0),
                          mke(0, 0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 4'd6, 32'hA01)));
        tbl.push_back(mkr("lw_err", mkv(OP_LW, 32'hB00, 32'h0, 5'd2, 1'b1, 32'h0, 2, 1'b0, 1'b1, 32'h0),
                          mke(2, 2, 1'b0, 4'hF, 32'h0, 32'hB00, 1'b0, 5'd0, 32'h0, 1'b1, 4'd5, 32'hB00)));
        tbl.push_back(mkr("lw_we0", mkv(OP_LW, 32'hC04, 32'h0, 5'd2, 1'b0, 32'h0, 1, 1'b1, 1'b0, 32'h12345678),
                          mke(1, 1, 1'b0, 4'hF, 32'h0, 32'hC04, 1'b0, 5'd0, 32'h0, 1'b0, 4'd5, 32'hB00)));
        tbl.push_back(mkr("lw_word", mkv(OP_LW, 32'hD08, 32'h0, 5'd4, 1'b1, 32'h0, 1, 1'b1, 1'b0, 32'h87654321),
                          mke(1, 1, 1'b0, 4'hF, 32'h0, 32'hD08, 1'b1, 5'd4, 32'h87654321, 1'b0, 4'd5, 32'hB00)));

        // Reset state, with a valid aligned load waiting on the inputs.
        rst_n = 1'b0; valid_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 32'h0; mem_data_i = 32'h0;
        reg_waddr_i = 5'd1; reg_we_i = 1'b1; reg_wdata_i = 32'h0;
        bus_ack_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = 32'h0;
        #23;
        checkOutput("reset.stall", stall_o, 1'b0);
        checkOutput("reset.bus_req", bus_req_o, 1'b0);
        checkOutput("reset.bus_be", bus_be_o, 4'h0);
        checkOutput("reset.wb_valid", wb_valid_o, 1'b0);
        checkOutput("reset.exc_valid", exc_valid_o, 1'b0);
        checkOutput("reset.exc_cause", exc_cause_o, 4'h0);
        @(negedge clk);
        valid_i = 1'b0; mem_op_i = OP_NONE; rst_n = 1'b1;

        $display("[TB] directed table: %0d entries", tbl.size());
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].v, o);
            checkTxn($sformatf("tbl[%0d].%s", i, tbl[i].name), tbl[i].e, o);
        end

        // Back-to-back: a new instruction presented in the result cycle is taken at once.
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = OP_LW; mem_addr_i = 32'h1000; reg_waddr_i = 5'd6; reg_we_i = 1'b1;
        bus_ack_i = 1'b0; bus_err_i = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus_req_o && n < 5);
        checkOutput("b2b.bus_req", bus_req_o, 1'b1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        #1;
        checkOutput("b2b.stall_on_ack", stall_o, 1'b0);
        @(negedge clk);
        bus_ack_i = 1'b0; mem_op_i = OP_NONE; reg_waddr_i = 5'd8; reg_we_i = 1'b1; reg_wdata_i = 32'h13579BDF;
        #1;
        checkOutput("b2b.first_wb", wb_valid_o, 1'b1);
        checkOutput("b2b.first_wdata", reg_wdata_o, 32'h0BADF00D);
        checkOutput("b2b.first_waddr", reg_waddr_o, 5'd6);
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        checkOutput("b2b.second_wb", wb_valid_o, 1'b1);
        checkOutput("b2b.second_wdata", reg_wdata_o, 32'h13579BDF);
        checkOutput("b2b.second_waddr", reg_waddr_o, 5'd8);

        // Reset asserted in the middle of a bus transaction.
        @(negedge clk);
        valid_i = 1'b1; mem_op_i = OP_SW; mem_addr_i = 32'h40; mem_data_i = 32'h55AA55AA;
        repeat (3) @(negedge clk);
        checkOutput("rst_mid.req_before", bus_req_o, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.bus_req", bus_req_o, 1'b0);
        checkOutput("rst_mid.stall", stall_o, 1'b0);
        checkOutput("rst_mid.bus_we", bus_we_o, 1'b0);
        @(negedge clk);
        valid_i = 1'b0; mem_op_i = OP_NONE; rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid.req_after_release", bus_req_o, 1'b0);

        // Randomized transactions against the reference model.
        last_cause = 4'd0;
        last_tval  = 32'h0;
        for (int i = 0; i < 60; i++) begin
            v.op    = ops[$urandom_range(0, 8)];
            v.addr  = $urandom;
            v.data  = $urandom;
            v.waddr = 5'($urandom);
            v.we    = 1'($urandom);
            v.wdata = $urandom;
            v.rdata = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                v.addr[0] = 1'b0;
                if (v.op == OP_LW || v.op == OP_SW) v.addr[1] = 1'b0;
            end
            v.resp_cycle = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
            v.resp_err   = ($urandom_range(0, 3) == 0);
            v.resp_ack   = v.resp_err ? 1'($urandom) : 1'b1;
            e = model(v, last_cause, last_tval);
            last_cause = e.cause;
            last_tval  = e.tval;
            applyStimulus(v, o);
            checkTxn($sformatf("rnd[%0d] op%0d a%0h", i, v.op, v.addr), e, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: ADDR_WIDTH, 32, byte address width of pipeline and bus.
REQ-002 Parameter: TIMEOUT, 16, BUSY cycles without ack/err before access fault (range 1..255).
REQ-003 Ports, in order:
- clk_i, in, 1: single clock; all state updates on rising edge.
- rst_n_i, in, 1: reset, asynchronous and active-low.
- valid_i, in, 1: instruction present from exe_mem.
- mem_op_i, in, 4: LB/LH/LW/LBU/LHU/SB/SH/SW/NONE, encodings from defines.v.
- mem_addr_i, in, ADDR_WIDTH: effective byte address.
- mem_data_i, in, 32: store data.
- reg_waddr_i / reg_we_i / reg_wdata_i, in, 5/1/32: writeback request.
- stall_o, out, 1: upstream shall hold all inputs while high.
- bus_req_o / bus_we_o, out, 1/1: bus request; write when high.
- bus_addr_o, out, ADDR_WIDTH: word-aligned address, [1:0]=0.
- bus_be_o / bus_wdata_o, out, 4/32: byte enables; lane-replicated store data.
- bus_ack_i / bus_err_i, in, 1/1: completion; error.
- bus_rdata_i, in, 32: read word, valid with bus_ack_i.
- wb_valid_o, out, 1: one-cycle result pulse to mem_wb.
- reg_waddr_o / reg_we_o / reg_wdata_o, out, 5/1/32: registered writeback.
- exc_valid_o / exc_cause_o / exc_tval_o, out, 1/4/ADDR_WIDTH: exception pulse, RISC-V cause code, faulting address.

Function
REQ-004 FSM states IDLE, BUSY; wb/exception outputs registered, valid for exactly one cycle.
REQ-005 IDLE, valid_i, mem_op_i=NONE: next cycle wb_valid_o=1, reg_* = inputs; no bus activity; stall_o=0.
REQ-006 Misaligned: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
REQ-007 IDLE, valid_i, misaligned op: no bus request; next cycle wb_valid_o=1, exc_valid_o=1, reg_we_o=0, exc_tval_o=mem_addr_i, cause 4 (load) / 6 (store); stall_o=0.
REQ-008 IDLE, valid_i, aligned mem op: stall_o=1 same cycle; capture op, offset, reg_waddr_i; next cycle enter BUSY with bus_req_o=1.
REQ-009 bus_be_o: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111; loads 4'b1111. bus_wdata_o: SB {4{d[7:0]}}, SH {2{d[15:0]}}, SW d; no read-modify-write.
REQ-010 bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o stable throughout BUSY; bus_req_o deasserts in the cycle after ack/err/timeout.
REQ-011 BUSY: stall_o=1 except in the cycle bus_ack_i, bus_err_i or timeout occurs, where stall_o=0.
REQ-012 BUSY with bus_ack_i: return IDLE; next cycle wb_valid_o=1; loads reg_we_o=reg_we_i captured, data selected by offset and sign/zero-extended (LB/LBU byte, LH/LHU half, LW word); stores reg_we_o=0.
REQ-013 BUSY with bus_err_i (wins over simultaneous bus_ack_i): return IDLE; next cycle exc_valid_o=1, cause 5 (load) / 7 (store), reg_we_o=0.
REQ-014 Cycle counter clears on BUSY entry, +1 per BUSY cycle; reaching TIMEOUT without ack/err behaves as bus_err_i.
REQ-015 Inputs ignored in BUSY; a new instruction presented in the cycle after completion is accepted normally (back-to-back, no bubble).
REQ-016 exc_cause_o, exc_tval_o hold last value when exc_valid_o=0; wb_valid_o=0 implies reg_we_o=0.

Reset
REQ-017 rst_n_i low, asynchronous: state IDLE, counter 0, all outputs 0, including mid-BUSY (bus_req_o drops without waiting for the clock).
REQ-018 First clock edge after rst_n_i rises is treated as IDLE with no pending request.

Verification
REQ-019 LB addr 0x103, ack after 3 cycles, rdata 0x80FF_FF00 -> bus_be_o=4'b1111, stall_o 1 for 3 cycles, reg_wdata_o=0xFFFF_FF80.
REQ-020 SH addr 0x202, data 0x1234_ABCD, immediate ack -> bus_be_o=4'b1100, bus_wdata_o=0xABCD_ABCD, wb_valid_o=1, reg_we_o=0.
REQ-021 LW addr 0x301 -> no bus_req_o, exc_valid_o=1, cause 4, tval 0x301, reg_we_o=0.
REQ-022 SW, bus never responds, TIMEOUT=16 -> bus_req_o high exactly 16 cycles, then exc_valid_o=1, cause 7.
REQ-023 LW with bus_ack_i and bus_err_i same cycle -> cause 5, reg_we_o=0; rst_n_i low mid-BUSY -> bus_req_o=0 before the next edge.
